led_scan_sequencer: RTL and testbench
=====================================

# led_scan_sequencer

Upstream driver for the 3-to-8 active-low LED decoder stage. Generates the decoder's `switch` select and `enable` code so that exactly one LED is lit and steps across the 8 positions at a programmable rate. Supports up, down and bounce patterns with start/pause/stop control. Outputs are registered and connect port-for-port to the decoder's `switch` and `enable` inputs.

## Interface

Parameters:
- `DIV_W`, default 8: width of the step-period prescaler.

Ports:
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: level-sampled each cycle. Starts the sequence from IDLE, or resumes it from HOLD.
- `stop`, input, 1: level-sampled each cycle. Pauses the sequence from RUN, or clears it from HOLD.
- `mode`, input, 2: pattern select, latched on IDLE→RUN.
  - 2'b00: up.
  - 2'b01: down.
  - 2'b10: bounce.
  - 2'b11: treated as up.
- `period`, input, DIV_W: dwell control, latched on IDLE→RUN. Each position is held `period`+1 cycles.
- `switch`, output, 3: LED index to the decoder.
- `enable`, output, 3: decoder enable code.
  - 3'b100 when lit.
  - 3'b000 when blank (all decoder outputs high).
- `busy`, output, 1: high in RUN and HOLD.
- `wrap`, output, 1: one-cycle pulse marking completion of one full pattern pass.

## Operation

Reset (async, immediate): all of the following hold until the first clock edge after `rst` falls.
- state = IDLE.
- `switch` = 0, `enable` = 3'b000, `busy` = 0, `wrap` = 0.
- prescaler = 0, direction = up.
- latched mode = 00, latched period = 0.

State machine, states IDLE, RUN, HOLD:
- **IDLE:**
  - Outputs: `enable` = 3'b000, `switch` = 0, `busy` = 0.
  - `start` && !`stop` → RUN. On this transition: latch `mode` and `period`, clear the prescaler, and load the start position.
    - Start position is 7 for down, 0 otherwise.
    - Direction is set to down for down mode, up otherwise.
- **RUN:**
  - Outputs: `enable` = 3'b100, `busy` = 1.
  - Prescaler increments each cycle.
  - When prescaler == latched period: prescaler clears to 0 and the position steps.
  - `stop` → HOLD. The step that would occur in that same cycle is suppressed.
- **HOLD:**
  - Outputs: `enable` = 3'b100 (current LED stays lit), `busy` = 1.
  - Prescaler and position are frozen.
  - `stop` → IDLE: position cleared and prescaler cleared.
  - `start` && !`stop` → RUN: resume with the prescaler and position retained.
- **Simultaneous `start` and `stop`:** `stop` wins in every state. In IDLE the state does not change.

Stepping rules (3-bit arithmetic):
- **Up:** position+1, wrapping 7→0. `wrap` pulses on the 7→0 step.
- **Down:** position−1, wrapping 0→7. `wrap` pulses on the 0→7 step.
- **Bounce:**
  - Moving up: at 7, the direction flips and the step goes to 6.
  - Moving down: at 0, the direction flips and the step goes to 1.
  - `wrap` pulses on the step that lands on 0.
  - Sequence: 0,1,…,7,6,…,1,0,1,… (14-step cycle).
- `mode` and `period` changes while `busy` is high have no effect until the next IDLE→RUN transition.

## Timing

- All outputs are registered; there is no combinational path from inputs to outputs.
- `start` sampled at edge N → at edge N: `enable` = 3'b100, `busy` = 1, `switch` = start position.
- With latched period P:
  - `switch` changes every P+1 cycles in RUN.
  - P = 0 steps every cycle.
  - P = 2^DIV_W−1 gives a dwell of 2^DIV_W cycles.
- `wrap` is high for exactly the cycle in which `switch` first shows the wrap position. It is low in IDLE and in HOLD.
- Pause/resume: dwell time is preserved.
  - The cycle count of the current position before pause plus after resume equals P+1.
  - Cycles spent in HOLD are not counted.
- `stop` sampled in HOLD at edge N → `enable` = 3'b000, `switch` = 0, `busy` = 0 at edge N.
- `rst` asserted mid-RUN or mid-HOLD forces the reset values immediately, without waiting for a clock edge.

## Test plan

- Reset check: assert `rst` mid-RUN → `enable` = 3'b000, `switch` = 0, `busy` = 0, `wrap` = 0 before the next clock edge. After release, the outputs stay at these values until `start`.
- Up mode, period = 0, `start` pulsed 1 cycle → `switch` = 0,1,2,…,7,0 on consecutive cycles. `wrap` is high only on the cycle `switch` returns to 0. `enable` = 3'b100 throughout.
- Down mode, period = 3 → `switch` = 7,6,5,… with each value held 4 cycles. `wrap` pulses when `switch` goes 0→7.
- Bounce mode, period = 0 → `switch` = 0,1,…,7,6,…,1,0,1. `wrap` pulses only on arrival at 0 (every 14 cycles).
- Pause/resume, up mode, period = 4:
  - `stop` raised 2 cycles into position 3 → `switch` stays 3 and `enable` stays 3'b100 for 10 HOLD cycles.
  - `start` raised → position 3 is held 3 more cycles, then the sequence steps to 4.
  - A second `stop` in HOLD → IDLE with `enable` = 3'b000.
- Simultaneous `start` = `stop` = 1 in IDLE → no transition. Changing `mode` and `period` while RUN → the step rate and pattern are unchanged until stop → IDLE → start.

Source files
------------

// File: rtl/led_scan_sequencer_if.sv
// Control and LED-select signals between a scan controller and the sequencer.
// The master drives start/stop/pattern settings; the slave returns decoder codes and status.
interface led_scan_sequencer_if #(
  parameter int DIV_W = 8
);
  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic [DIV_W-1:0] period;
  logic [2:0]       switch;
  logic [2:0]       enable;
  logic             busy;
  logic             wrap;

  modport master (
    output start, stop, mode, period,
    input  switch, enable, busy, wrap
  );

  modport slave (
    input  start, stop, mode, period,
    output switch, enable, busy, wrap
  );
endinterface

// File: rtl/led_scan_sequencer.sv
// Drives a 3-to-8 active-low LED decoder so that one LED is lit and scans
// up, down or bouncing across the eight positions at a programmable dwell.
module led_scan_sequencer #(
  parameter int DIV_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  led_scan_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic       DIR_UP      = 1'b0;
  localparam logic       DIR_DOWN    = 1'b1;

  state_t           state_q, state_d;
  logic [2:0]       pos_q, pos_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic             wrap_q, wrap_d;
  logic [2:0]       enable_q, enable_d;
  logic             busy_q, busy_d;

  logic [2:0] step_pos;
  logic       step_dir;
  logic       step_wrap;

  // Next position for one step of the latched pattern.
  always_comb begin
    step_pos  = pos_q + 3'd1;
    step_dir  = dir_q;
    step_wrap = (pos_q == 3'd7);
    case (mode_q)
      MODE_DOWN: begin
        step_pos  = pos_q - 3'd1;
        step_wrap = (pos_q == 3'd0);
      end
      MODE_BOUNCE: begin
        step_wrap = 1'b0;
        if (dir_q == DIR_UP) begin
          if (pos_q == 3'd7) begin
            step_pos = 3'd6;
            step_dir = DIR_DOWN;
          end
        end else if (pos_q == 3'd0) begin
          step_pos = 3'd1;
          step_dir = DIR_UP;
        end else begin
          step_pos  = pos_q - 3'd1;
          step_wrap = (pos_q == 3'd1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    presc_d  = presc_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    period_d = period_q;
    wrap_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d  = RUN;
          mode_d   = bus.mode;
          period_d = bus.period;
          presc_d  = '0;
          pos_d    = (bus.mode == MODE_DOWN) ? 3'd7 : 3'd0;
          dir_d    = (bus.mode == MODE_DOWN) ? DIR_DOWN : DIR_UP;
        end
      end
      RUN: begin
        if (bus.stop) begin
          // The pausing cycle still counts toward dwell; only the step is deferred.
          state_d = HOLD;
          if (presc_q != period_q) begin
            presc_d = presc_q + DIV_W'(1);
          end
        end else if (presc_q == period_q) begin
          presc_d = '0;
          pos_d   = step_pos;
          dir_d   = step_dir;
          wrap_d  = step_wrap;
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end
      HOLD: begin
        if (bus.stop) begin
          state_d = IDLE;
          pos_d   = 3'd0;
          presc_d = '0;
        end else if (bus.start) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d   = (state_d != IDLE);
    enable_d = busy_d ? 3'b100 : 3'b000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pos_q    <= 3'd0;
      presc_q  <= '0;
      dir_q    <= DIR_UP;
      mode_q   <= 2'b00;
      period_q <= '0;
      wrap_q   <= 1'b0;
      enable_q <= 3'b000;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      presc_q  <= presc_d;
      dir_q    <= dir_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      wrap_q   <= wrap_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.switch = pos_q;
  assign bus.enable = enable_q;
  assign bus.busy   = busy_q;
  assign bus.wrap   = wrap_q;

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Directed and randomized checks of led_scan_sequencer against a pattern-table model.
module tb_led_scan_sequencer;

  localparam int DIV_W = 8;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  bit   check_en = 0;

  led_scan_sequencer_if #(.DIV_W(DIV_W)) bus ();

  led_scan_sequencer #(.DIV_W(DIV_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the pattern is a list of positions; we track list index and elapsed dwell.
  typedef struct {
    bit active;
    bit paused;
    int idx;
    int e;
    int mode;
    int p;
    bit wrap;
  } model_t;

  model_t m;

  function automatic int seq_len(int md);
    return (md == 2) ? 14 : 8;
  endfunction

  function automatic int seq_pos(int md, int idx);
    if (md == 1) return 7 - idx;
    if (md == 2) return (idx <= 7) ? idx : 14 - idx;
    return idx;
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r.active = 0; r.paused = 0; r.idx = 0; r.e = 0; r.mode = 0; r.p = 0; r.wrap = 0;
    return r;
  endfunction

  function automatic model_t model_step(model_t c, bit st, bit sp, int md, int pd);
    model_t n = c;
    n.wrap = 0;
    if (!c.active) begin
      if (st && !sp) begin
        n.active = 1; n.paused = 0; n.idx = 0; n.e = 0; n.mode = md; n.p = pd;
      end
    end else if (c.paused) begin
      if (sp) begin
        n.active = 0; n.paused = 0; n.idx = 0; n.e = 0;
      end else if (st) begin
        n.paused = 0;
      end
    end else if (sp) begin
      n.paused = 1;
      if (c.e < c.p) n.e = c.e + 1;
    end else if (c.e == c.p) begin
      n.e = 0;
      n.idx = (c.idx + 1) % seq_len(c.mode);
      n.wrap = (n.idx == 0);
    end else begin
      n.e = c.e + 1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= model_reset();
    else     m <= model_step(m, bus.start, bus.stop, int'(bus.mode), int'(bus.period));
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_switch", 8'(bus.switch), m.active ? 8'(seq_pos(m.mode, m.idx)) : 8'd0);
      chk("model_enable", 8'(bus.enable), m.active ? 8'd4 : 8'd0);
      chk("model_busy",   8'(bus.busy),   m.active ? 8'd1 : 8'd0);
      chk("model_wrap",   8'(bus.wrap),   m.wrap ? 8'd1 : 8'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_run(input logic [1:0] md, input logic [DIV_W-1:0] pd);
    bus.mode = md;
    bus.period = pd;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic to_idle();
    bus.stop = 1'b1;
    tick();
    tick();
    bus.stop = 1'b0;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_switch"}, 8'(bus.switch), 8'd0);
    chk({name, "_enable"}, 8'(bus.enable), 8'd0);
    chk({name, "_busy"},   8'(bus.busy),   8'd0);
    chk({name, "_wrap"},   8'(bus.wrap),   8'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.mode = 2'b00;
    bus.period = '0;
    tick();
    check_en = 1;
    tick();
    chk_idle("reset_state");
    rst = 1'b0;
    tick();
    chk_idle("post_reset");

    // Up, period 0: one step per cycle, wrap on return to 0.
    start_run(2'b00, 8'd0);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) tick();
      chk("up_switch", 8'(bus.switch), 8'(k % 8));
      chk("up_wrap",   8'(bus.wrap),   (k == 8) ? 8'd1 : 8'd0);
      chk("up_enable", 8'(bus.enable), 8'd4);
    end
    to_idle();
    chk_idle("up_idle");

    // Down, period 3: each value held 4 cycles, wrap on 0->7.
    start_run(2'b01, 8'd3);
    for (int k = 0; k <= 35; k++) begin
      if (k > 0) tick();
      chk("down_switch", 8'(bus.switch), 8'((7 - (k / 4)) & 7));
      chk("down_wrap",   8'(bus.wrap),   (k == 32) ? 8'd1 : 8'd0);
    end
    to_idle();

    // Bounce, period 0: 14-step cycle, wrap on arrival at 0.
    start_run(2'b10, 8'd0);
    for (int k = 0; k <= 29; k++) begin
      int ix;
      if (k > 0) tick();
      ix = k % 14;
      chk("bounce_switch", 8'(bus.switch), 8'((ix <= 7) ? ix : 14 - ix));
      chk("bounce_wrap",   8'(bus.wrap),   (k > 0 && ix == 0) ? 8'd1 : 8'd0);
    end
    to_idle();

    // Pause two cycles into position 3, hold 10 cycles, resume for the remaining 3.
    start_run(2'b00, 8'd4);
    for (int k = 1; k <= 16; k++) tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("pause_switch", 8'(bus.switch), 8'd3);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("hold_switch", 8'(bus.switch), 8'd3);
      chk("hold_enable", 8'(bus.enable), 8'd4);
      chk("hold_busy",   8'(bus.busy),   8'd1);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("resume_r0", 8'(bus.switch), 8'd3);
    tick();
    chk("resume_r1", 8'(bus.switch), 8'd3);
    tick();
    chk("resume_r2", 8'(bus.switch), 8'd3);
    tick();
    chk("resume_step", 8'(bus.switch), 8'd4);
    to_idle();
    chk_idle("hold_stop");

    // start and stop together in IDLE: stop wins.
    bus.start = 1'b1;
    bus.stop = 1'b1;
    tick();
    tick();
    chk_idle("start_stop_idle");
    bus.start = 1'b0;
    bus.stop = 1'b0;

    // Mode/period changes while running are ignored until the next start.
    start_run(2'b00, 8'd1);
    bus.mode = 2'b10;
    bus.period = 8'd5;
    for (int k = 0; k <= 19; k++) begin
      if (k > 0) tick();
      chk("latched_switch", 8'(bus.switch), 8'((k / 2) % 8));
    end
    to_idle();
    start_run(2'b10, 8'd5);
    for (int k = 1; k <= 5; k++) tick();
    chk("relatch_dwell", 8'(bus.switch), 8'd0);
    tick();
    chk("relatch_step", 8'(bus.switch), 8'd1);

    // Asynchronous reset mid-run.
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    #1;
    chk_idle("async_reset");
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_idle("after_reset");
    end

    // Random control traffic, checked every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom_range(0, 5) == 0);
      bus.stop = ($urandom_range(0, 11) == 0);
      bus.mode = 2'($urandom_range(0, 3));
      bus.period = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(0, 6));
      tick();
    end
    bus.start = 1'b0;
    bus.stop = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
